mc_ctrl_fsm: RTL and testbench



---
 rtl/mc_ctrl_fsm.sv | 195 +++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle main control FSM for the single-ALU RISC-V datapath
//
// Sequences fetch, decode, execute, memory access and write-back, sharing one
// ALU for PC+4, address/branch-target calculation, arithmetic and BEQ compare.
// Optional feature macro: CTRL_RETIRE_CNT_EN adds a 32-bit retired-instruction
// counter output (retired_cnt); without it the port and counter are absent.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   opcode[6:0]     instruction[6:0] from the IR
//   zero            ALU zero flag (used in BRANCH)
//   mem_ready       memory completes the current read/write this cycle
//   pc_en, pc_src   PC load enable / PC source (0 ALU result, 1 ALUOut)
//   i_or_d          memory address select (0 PC, 1 ALUOut)
//   mem_read/write  memory requests
//   ir_write        instruction register load
//   mem_to_reg      write-back source (0 ALUOut, 1 MDR)
//   reg_write       register file write enable
//   alu_src_a       0 PC, 1 rs1
//   alu_src_b[1:0]  00 rs2, 01 const 4, 10 immediate
//   alu_op[1:0]     00 add, 01 sub, 10 R-type funct, 11 I-type funct
//   trap            sticky illegal-opcode flag
//   state[3:0]      current state (debug)
//   retired_cnt     (CTRL_RETIRE_CNT_EN only) retired instruction count
module mc_ctrl_fsm (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        pc_src,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        trap,
  output logic [3:0]  state
`ifdef CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] retired_cnt
`endif
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_EXEC     = 4'd7;
  localparam logic [3:0] S_ALU_WB   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_TRAP     = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [3:0] state_q;
  logic [3:0] state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_RTYPE, OP_ITYPE: state_d = S_EXEC;
          OP_BRANCH:          state_d = S_BRANCH;
          default:            state_d = S_TRAP;
        endcase
      end
      // Only load/store reach MEM_ADDR, so anything not a store is a load.
      S_MEM_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC:     state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore decode, except FETCH (pc_en/ir_write follow mem_ready) and
  // BRANCH (pc_en follows zero). Reset forces state_q to IDLE, so every
  // output drops asynchronously with rst_n.
  always_comb begin
    pc_en      = 1'b0;
    pc_src     = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    trap       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        if (opcode == OP_RTYPE) begin
          alu_src_b = 2'b00;
          alu_op    = 2'b10;
        end else begin
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
        end
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_en     = zero;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state = state_q;

`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] retired_cnt_q;
  logic        retire;

  assign retire = (state_q == S_MEM_WB) || (state_q == S_ALU_WB) ||
                  (state_q == S_BRANCH) ||
                  ((state_q == S_MEM_WR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_q <= 32'd0;
    end else if (retire) begin
      retired_cnt_q <= retired_cnt_q + 32'd1;
    end
  end

  assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed self-checking bench for mc_ctrl_fsm
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_write, alu_src_a, trap;
  logic [1:0]  alu_src_b, alu_op;
  logic [3:0]  state;
`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] retired_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .pc_src     (pc_src),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .trap       (trap),
    .state      (state)
`ifdef CTRL_RETIRE_CNT_EN
    ,
    .retired_cnt(retired_cnt)
`endif
  );

  // Field order: pc_en pc_src i_or_d mem_read mem_write ir_write mem_to_reg
  //              reg_write alu_src_a alu_src_b[1:0] alu_op[1:0] trap
  logic [13:0] ctrl;
  assign ctrl = {pc_en, pc_src, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, alu_op, trap};

  localparam logic [13:0] C_IDLE   = 14'b0_0_0_0_0_0_0_0_0_00_00_0;
  localparam logic [13:0] C_FETCH1 = 14'b1_0_0_1_0_1_0_0_0_01_00_0;
  localparam logic [13:0] C_FETCH0 = 14'b0_0_0_1_0_0_0_0_0_01_00_0;
  localparam logic [13:0] C_DEC    = 14'b0_0_0_0_0_0_0_0_0_10_00_0;
  localparam logic [13:0] C_MADDR  = 14'b0_0_0_0_0_0_0_0_1_10_00_0;
  localparam logic [13:0] C_MRD    = 14'b0_0_1_1_0_0_0_0_0_00_00_0;
  localparam logic [13:0] C_MWB    = 14'b0_0_0_0_0_0_1_1_0_00_00_0;
  localparam logic [13:0] C_MWR    = 14'b0_0_1_0_1_0_0_0_0_00_00_0;
  localparam logic [13:0] C_EXR    = 14'b0_0_0_0_0_0_0_0_1_00_10_0;
  localparam logic [13:0] C_EXI    = 14'b0_0_0_0_0_0_0_0_1_10_11_0;
  localparam logic [13:0] C_AWB    = 14'b0_0_0_0_0_0_0_1_0_00_00_0;
  localparam logic [13:0] C_BR1    = 14'b1_1_0_0_0_0_0_0_1_00_01_0;
  localparam logic [13:0] C_BR0    = 14'b0_1_0_0_0_0_0_0_1_00_01_0;
  localparam logic [13:0] C_TRAP   = 14'b0_0_0_0_0_0_0_0_0_00_00_1;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Pulses reset for one cycle and releases it on a falling edge; state is IDLE
  // until the next rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = OP_R;
    zero = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (state !== 4'd0) begin
        n_fail++;
        $display("FAIL reset_state[%0d] got %0d want 0", i, state);
      end
      n_tests++;
      if (ctrl !== C_IDLE) begin
        n_fail++;
        $display("FAIL reset_ctrl[%0d] got %b want %b", i, ctrl, C_IDLE);
      end
      @(negedge clk);
    end
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_release_idle got %0d want 0", state);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (state !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_first_fetch got %0d want 1", state);
    end
  endtask

  task automatic test_rtype();
    logic [3:0]  es [6];
    logic [13:0] ec [6];
    es = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
    ec = '{C_IDLE, C_FETCH1, C_DEC, C_EXR, C_AWB, C_FETCH1};
    opcode = OP_R;
    mem_ready = 1'b1;
    zero = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      #1;
      n_tests++;
      if (state !== es[i]) begin
        n_fail++;
        $display("FAIL rtype_state[%0d] got %0d want %0d", i, state, es[i]);
      end
      n_tests++;
      if (ctrl !== ec[i]) begin
        n_fail++;
        $display("FAIL rtype_ctrl[%0d] got %b want %b", i, ctrl, ec[i]);
      end
      @(negedge clk);
    end
  endtask

  // Two wait cycles in MEM_RD: FETCH-to-FETCH is 7 cycles.
  task automatic test_lw_wait();
    logic [3:0]  es [9];
    logic [13:0] ec [9];
    logic        mr [9];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5, 4'd1};
    ec = '{C_IDLE, C_FETCH1, C_DEC, C_MADDR, C_MRD, C_MRD, C_MRD, C_MWB, C_FETCH1};
    mr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    opcode = OP_LW;
    zero = 1'b0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      mem_ready = mr[i];
      #1;
      n_tests++;
      if (state !== es[i]) begin
        n_fail++;
        $display("FAIL lw_state[%0d] got %0d want %0d", i, state, es[i]);
      end
      n_tests++;
      if (ctrl !== ec[i]) begin
        n_fail++;
        $display("FAIL lw_ctrl[%0d] got %b want %b", i, ctrl, ec[i]);
      end
      @(negedge clk);
    end
  endtask

  // BEQ taken then not taken; mem_ready low outside FETCH must not stall.
  task automatic test_beq();
    logic [3:0]  es [8];
    logic [13:0] ec [8];
    logic        mr [8];
    logic        zr [8];
    es = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd9, 4'd1};
    ec = '{C_IDLE, C_FETCH1, C_DEC, C_BR1, C_FETCH1, C_DEC, C_BR0, C_FETCH1};
    mr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    zr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    opcode = OP_BEQ;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      zero = zr[i];
      #1;
      n_tests++;
      if (state !== es[i]) begin
        n_fail++;
        $display("FAIL beq_state[%0d] got %0d want %0d", i, state, es[i]);
      end
      n_tests++;
      if (ctrl !== ec[i]) begin
        n_fail++;
        $display("FAIL beq_ctrl[%0d] got %b want %b", i, ctrl, ec[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_trap();
    logic [3:0]  es [4];
    logic [13:0] ec [4];
    es = '{4'd0, 4'd1, 4'd2, 4'd10};
    ec = '{C_IDLE, C_FETCH1, C_DEC, C_TRAP};
    opcode = OP_BAD;
    mem_ready = 1'b1;
    zero = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (state !== es[i]) begin
        n_fail++;
        $display("FAIL trap_entry_state[%0d] got %0d want %0d", i, state, es[i]);
      end
      n_tests++;
      if (ctrl !== ec[i]) begin
        n_fail++;
        $display("FAIL trap_entry_ctrl[%0d] got %b want %b", i, ctrl, ec[i]);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      zero = i[1];
      opcode = (i[2]) ? OP_R : OP_LW;
      #1;
      n_tests++;
      if (state !== 4'd10 || ctrl !== C_TRAP) begin
        n_fail++;
        $display("FAIL trap_hold[%0d] state %0d ctrl %b want 10 %b", i, state, ctrl, C_TRAP);
      end
      @(negedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (trap !== 1'b0 || state !== 4'd0) begin
      n_fail++;
      $display("FAIL trap_reset trap %b state %0d want 0 0", trap, state);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_store();
    logic [3:0]  es [5];
    logic [13:0] ec [5];
    es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6};
    ec = '{C_IDLE, C_FETCH1, C_DEC, C_MADDR, C_MWR};
    opcode = OP_SW;
    zero = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      mem_ready = (i < 4);
      #1;
      n_tests++;
      if (state !== es[i]) begin
        n_fail++;
        $display("FAIL sw_state[%0d] got %0d want %0d", i, state, es[i]);
      end
      n_tests++;
      if (ctrl !== ec[i]) begin
        n_fail++;
        $display("FAIL sw_ctrl[%0d] got %b want %b", i, ctrl, ec[i]);
      end
      @(negedge clk);
    end
    #1;
    n_tests++;
    if (state !== 4'd6 || mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_wait_hold state %0d mem_write %b want 6 1", state, mem_write);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (mem_write !== 1'b0 || state !== 4'd0) begin
      n_fail++;
      $display("FAIL sw_reset_drop mem_write %b state %0d want 0 0", mem_write, state);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (ctrl !== C_IDLE) begin
      n_fail++;
      $display("FAIL sw_reset_quiet ctrl %b want %b", ctrl, C_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL sw_release_idle got %0d want 0", state);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (state !== 4'd1) begin
      n_fail++;
      $display("FAIL sw_release_fetch got %0d want 1", state);
    end
  endtask

  // SW then I-type with a FETCH stall; opcode garbage outside its sampling states.
  task automatic test_back_to_back();
    logic [3:0]  es [11];
    logic [13:0] ec [11];
    logic        mr [11];
    logic [6:0]  op [11];
    es = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd6, 4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
    ec = '{C_IDLE, C_FETCH0, C_FETCH1, C_DEC, C_MADDR, C_MWR,
           C_FETCH1, C_DEC, C_EXI, C_AWB, C_FETCH1};
    mr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    op = '{OP_BAD, OP_BAD, OP_BEQ, OP_SW, OP_SW, OP_BAD,
           OP_BAD, OP_I, OP_I, OP_BAD, OP_R};
    zero = 1'b0;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      mem_ready = mr[i];
      opcode = op[i];
      #1;
      n_tests++;
      if (state !== es[i]) begin
        n_fail++;
        $display("FAIL b2b_state[%0d] got %0d want %0d", i, state, es[i]);
      end
      n_tests++;
      if (ctrl !== ec[i]) begin
        n_fail++;
        $display("FAIL b2b_ctrl[%0d] got %b want %b", i, ctrl, ec[i]);
      end
      @(negedge clk);
    end
  endtask

`ifdef CTRL_RETIRE_CNT_EN
  // R (4 cycles), LW (5), SW (4), BEQ (3), all with mem_ready=1.
  task automatic test_retire_cnt();
    mem_ready = 1'b1;
    zero = 1'b0;
    do_reset();
    #1;
    n_tests++;
    if (retired_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL retire_reset got %0d want 0", retired_cnt);
    end
    @(negedge clk);
    opcode = OP_R;
    repeat (4) @(negedge clk);
    opcode = OP_LW;
    repeat (5) @(negedge clk);
    opcode = OP_SW;
    repeat (4) @(negedge clk);
    opcode = OP_BEQ;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (state !== 4'd1 || retired_cnt !== 32'd4) begin
      n_fail++;
      $display("FAIL retire_count state %0d cnt %0d want 1 4", state, retired_cnt);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_trap();
    test_reset_mid_store();
    test_back_to_back();
`ifdef CTRL_RETIRE_CNT_EN
    test_retire_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
